muldiv_unit: RTL and testbench

Parametrised sequential multiply/divide unit with HI/LO result registers for the MIPS datapath, executing MULT, MULTU, DIV and DIVU. It generalises the plain N-bit adder into a multi-cycle radix-2 shift-add / shift-subtract engine built around one (N+1)-bit adder/subtractor. It sits beside the ALU in EX: the pipeline issues `start` with operands, stalls on `busy`, and later reads `hi`/`lo` (MFHI/MFLO) or writes them (MTHI/MTLO).

---
 rtl/muldiv_pkg.sv | 31 +++
 rtl/muldiv_if.sv | 34 +++
 rtl/muldiv_addsub.sv | 26 ++
 rtl/muldiv_unit.sv | 185 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// ---------------------------------------------------------------------------
// muldiv_pkg
// Shared definitions for the sequential multiply/divide unit.
//   OP_*      : operation encodings driven on the op bus (bit 1 = divide,
//               bit 0 = signed).
//   state_e   : control FSM states.
//   MD_N      : default operand width.
//   cnt_width : width of the iteration counter for a given operand width.
// ---------------------------------------------------------------------------
package muldiv_pkg;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_e;

  localparam int MD_N     = 32;
  localparam int MD_CNT_W = $clog2(MD_N + 1);

  // Counter must hold the value n itself, hence n+1 codes.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// ---------------------------------------------------------------------------
// muldiv_if
// Bus between the EX stage (master) and the multiply/divide unit (slave).
//   start/op/A/B      : operation launch and operands
//   wr_hi/wr_lo/wr_data : MTHI/MTLO writes
//   busy/done/dz      : status (dz only meaningful while done=1)
//   hi/lo             : result registers
// ---------------------------------------------------------------------------
interface muldiv_if #(
  parameter int N = 32
);
  logic         start;
  logic [1:0]   op;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         wr_hi;
  logic         wr_lo;
  logic [N-1:0] wr_data;
  logic         busy;
  logic         done;
  logic         dz;
  logic [N-1:0] hi;
  logic [N-1:0] lo;

  modport master (
    output start, op, A, B, wr_hi, wr_lo, wr_data,
    input  busy, done, dz, hi, lo
  );

  modport slave (
    input  start, op, A, B, wr_hi, wr_lo, wr_data,
    output busy, done, dz, hi, lo
  );
endinterface

// File: rtl/muldiv_addsub.sv
// ---------------------------------------------------------------------------
// addsub_n
// W-bit adder/subtractor shared by the multiply and divide iterations.
//   i_a, i_b : operands
//   i_sub    : 0 = i_a + i_b, 1 = i_a - i_b
//   o_sum    : W-bit result
//   o_cb     : carry out when adding, borrow out when subtracting
// ---------------------------------------------------------------------------
module addsub_n #(
  parameter int W = 33
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_sub,
  output logic [W-1:0] o_sum,
  output logic         o_cb
);
  logic [W-1:0] w_b_eff;
  logic [W:0]   w_full;

  assign w_b_eff = i_sub ? ~i_b : i_b;
  assign w_full  = {1'b0, i_a} + {1'b0, w_b_eff} + {{W{1'b0}}, i_sub};
  assign o_sum   = w_full[W-1:0];
  // Subtraction is a + ~b + 1, so a borrow is the absence of a carry.
  assign o_cb    = w_full[W] ^ i_sub;
endmodule

// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit
// Multi-cycle radix-2 multiply/divide unit with HI/LO registers
// (MULTU, MULT, DIVU, DIV). One result bit per cycle over N cycles, then one
// sign-fix cycle: latency N+1 from the start edge to the done pulse.
//   clk     : rising-edge clock
//   reset_n : synchronous active-low reset
//   bus     : muldiv_if slave (start/op/A/B, wr_hi/wr_lo/wr_data,
//             busy/done/dz/hi/lo)
// ---------------------------------------------------------------------------
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int N = 32
) (
  input  logic     clk,
  input  logic     reset_n,
  muldiv_if.slave  bus
);
  localparam int CW = cnt_width(N);

  state_e         r_state, w_state_next;
  logic [1:0]     r_op;
  logic [N-1:0]   r_opnd;     // multiplicand |A| or divisor |B|
  logic [N-1:0]   r_acc_hi;   // upper partial product / partial remainder
  logic [N-1:0]   r_acc_lo;   // multiplier bits / dividend-then-quotient
  logic [N-1:0]   r_hi, r_lo;
  logic [CW-1:0]  r_cnt;
  logic           r_neg_q;    // negate product or quotient at FIX
  logic           r_neg_r;    // negate remainder at FIX (dividend sign)
  logic           r_dz;
  logic           r_done;
  logic           r_dz_out;

  logic           w_accept, w_iter, w_fix;

  // ---------------- control FSM ----------------
  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_iter       = 1'b0;
    w_fix        = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_accept     = 1'b1;
          w_state_next = CALC;
        end
      end
      CALC: begin
        w_iter = 1'b1;
        // Counter is about to reach 0 on this edge.
        if (r_cnt == CW'(1)) w_state_next = FIX;
      end
      FIX: begin
        w_fix        = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // ---------------- operand preparation ----------------
  logic         w_signed_in, w_div_in, w_a_neg, w_b_neg;
  logic [N-1:0] w_a_mag, w_b_mag;

  assign w_signed_in = bus.op[0];
  assign w_div_in    = bus.op[1];
  assign w_a_neg     = w_signed_in & bus.A[N-1];
  assign w_b_neg     = w_signed_in & bus.B[N-1];
  assign w_a_mag     = w_a_neg ? -bus.A : bus.A;
  assign w_b_mag     = w_b_neg ? -bus.B : bus.B;

  // ---------------- iteration datapath ----------------
  logic         w_is_div;
  logic [N:0]   w_add_a, w_add_b, w_sum, w_pp;
  logic         w_cb;
  logic [N-1:0] w_acc_hi_next, w_acc_lo_next;

  assign w_is_div = r_op[1];
  // Divide: remainder shifted left with the next dividend bit pulled in.
  // Multiply: upper half of the partial product, zero-extended.
  assign w_add_a  = w_is_div ? {r_acc_hi, r_acc_lo[N-1]} : {1'b0, r_acc_hi};
  assign w_add_b  = {1'b0, r_opnd};

  addsub_n #(.W(N + 1)) u_addsub (
    .i_a   (w_add_a),
    .i_b   (w_add_b),
    .i_sub (w_is_div),
    .o_sum (w_sum),
    .o_cb  (w_cb)
  );

  always_comb begin
    w_acc_hi_next = r_acc_hi;
    w_acc_lo_next = r_acc_lo;
    w_pp          = '0;
    if (w_is_div) begin
      // Restoring step: keep the difference only when it did not borrow.
      w_acc_hi_next = w_cb ? w_add_a[N-1:0] : w_sum[N-1:0];
      w_acc_lo_next = {r_acc_lo[N-2:0], ~w_cb};
    end else begin
      w_pp          = r_acc_lo[0] ? w_sum : w_add_a;
      w_acc_hi_next = w_pp[N:1];
      w_acc_lo_next = {w_pp[0], r_acc_lo[N-1:1]};
    end
  end

  // ---------------- sign fix ----------------
  logic [2*N-1:0] w_prod, w_prod_neg;
  logic [N-1:0]   w_hi_res, w_lo_res;

  assign w_prod     = {r_acc_hi, r_acc_lo};
  assign w_prod_neg = -w_prod;

  always_comb begin
    w_hi_res = r_acc_hi;
    w_lo_res = r_acc_lo;
    if (!w_is_div) begin
      {w_hi_res, w_lo_res} = r_neg_q ? w_prod_neg : w_prod;
    end else begin
      // With a zero divisor the remainder register ends up holding |A|,
      // so the dividend-sign fix restores the original A.
      w_lo_res = r_dz ? '1 : (r_neg_q ? -r_acc_lo : r_acc_lo);
      w_hi_res = r_neg_r ? -r_acc_hi : r_acc_hi;
    end
  end

  // ---------------- registers ----------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_op     <= OP_MULTU;
      r_opnd   <= '0;
      r_acc_hi <= '0;
      r_acc_lo <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_cnt    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dz     <= 1'b0;
      r_done   <= 1'b0;
      r_dz_out <= 1'b0;
    end else begin
      r_done   <= 1'b0;
      r_dz_out <= 1'b0;
      if (w_accept) begin
        // start wins over a same-cycle MTHI/MTLO.
        r_op     <= bus.op;
        r_opnd   <= w_div_in ? w_b_mag : w_a_mag;
        r_acc_lo <= w_div_in ? w_a_mag : w_b_mag;
        r_acc_hi <= '0;
        r_cnt    <= CW'(N);
        r_neg_q  <= w_a_neg ^ w_b_neg;
        r_neg_r  <= w_a_neg;
        r_dz     <= w_div_in && (bus.B == '0);
      end else if (r_state == IDLE) begin
        if (bus.wr_hi) r_hi <= bus.wr_data;
        if (bus.wr_lo) r_lo <= bus.wr_data;
      end
      if (w_iter) begin
        r_cnt    <= r_cnt - CW'(1);
        r_acc_hi <= w_acc_hi_next;
        r_acc_lo <= w_acc_lo_next;
      end
      if (w_fix) begin
        r_hi     <= w_hi_res;
        r_lo     <= w_lo_res;
        r_done   <= 1'b1;
        r_dz_out <= r_dz;
      end
    end
  end

  assign bus.busy = (r_state != IDLE);
  assign bus.done = r_done;
  assign bus.dz   = r_dz_out;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;
endmodule

// File: tb/tb_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_muldiv_unit
// Directed self-checking bench for muldiv_unit (N=32) with hand-computed
// expected values. Inputs change and outputs are sampled 1 time unit after
// each rising edge.
// ---------------------------------------------------------------------------
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic clk;
  logic reset_n;
  int   n_tests;
  int   n_fail;

  muldiv_if #(.N(32)) bus ();

  muldiv_unit #(.N(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present start for one edge, then scramble the operands.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.A     = a;
    bus.B     = b;
    tick();
    bus.start = 1'b0;
    bus.A     = $urandom;
    bus.B     = $urandom;
  endtask

  // Ticks until done; lat counts edges since the start edge.
  task automatic wait_done(input int start_cnt, output int lat, output int busy_cnt);
    lat      = start_cnt;
    busy_cnt = 0;
    do begin
      tick();
      lat++;
      if (!bus.done && bus.busy) busy_cnt++;
    end while (!bus.done && lat < 200);
    if (!bus.done) check("done_timeout", 64'(bus.done), 64'd1);
  endtask

  task automatic run_op(input string name, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input logic exp_dz);
    int lat, bc;
    issue(op, a, b);
    check({name, "_busy_start"}, 64'(bus.busy), 64'd1);
    wait_done(0, lat, bc);
    check({name, "_latency"}, 64'(lat), 64'd33);
    check({name, "_busy_cycles"}, 64'(bc), 64'd32);
    check({name, "_busy_done"}, 64'(bus.busy), 64'd0);
    check({name, "_hi"}, 64'(bus.hi), 64'(exp_hi));
    check({name, "_lo"}, 64'(bus.lo), 64'(exp_lo));
    check({name, "_dz"}, 64'(bus.dz), 64'(exp_dz));
    $display("[TB] %s op=%0d A=0x%08h B=0x%08h -> hi=0x%08h lo=0x%08h dz=%0b lat=%0d",
             name, op, a, b, bus.hi, bus.lo, bus.dz, lat);
  endtask

  initial begin
    int lat, bc, n_done;
    n_tests      = 0;
    n_fail       = 0;
    reset_n      = 1'b0;
    bus.start    = 1'b0;
    bus.op       = OP_MULTU;
    bus.A        = '0;
    bus.B        = '0;
    bus.wr_hi    = 1'b0;
    bus.wr_lo    = 1'b0;
    bus.wr_data  = '0;

    tick();
    tick();
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_dz",   64'(bus.dz),   64'd0);
    check("rst_hi",   64'(bus.hi),   64'd0);
    check("rst_lo",   64'(bus.lo),   64'd0);
    $display("[TB] reset -> busy=%0b hi=0x%08h lo=0x%08h", bus.busy, bus.hi, bus.lo);
    reset_n = 1'b1;
    tick();

    // Multiply
    run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    run_op("mult_neg",  OP_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    // Issued in the done cycle of the previous operation.
    run_op("mult_b2b",  OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0);

    // Divide
    run_op("div_neg",   OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("divu_7_2",  OP_DIVU,  32'd7,         32'd2,         32'd1,         32'd3,         1'b0);
    run_op("div_ovf",   OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0);
    run_op("divu_dz",   OP_DIVU,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1'b1);
    tick();
    check("dz_after_done",   64'(bus.dz),   64'd0);
    check("done_after_done", 64'(bus.done), 64'd0);

    // Start ignored mid-operation, MTHI ignored while busy.
    issue(OP_MULTU, 32'h1234_5678, 32'h0000_0100);
    repeat (4) tick();
    bus.start = 1'b1;
    bus.op    = OP_DIVU;
    bus.A     = 32'd1;
    bus.B     = 32'd1;
    tick();
    bus.start   = 1'b0;
    bus.wr_hi   = 1'b1;
    bus.wr_data = 32'h0000_1234;
    tick();
    bus.wr_hi = 1'b0;
    check("wrhi_busy_hi", 64'(bus.hi), 64'd5);
    wait_done(6, lat, bc);
    check("hazard_latency", 64'(lat), 64'd33);
    check("hazard_hi", 64'(bus.hi), 64'h12);
    check("hazard_lo", 64'(bus.lo), 64'h3456_7800);
    $display("[TB] hazard multu -> hi=0x%08h lo=0x%08h lat=%0d", bus.hi, bus.lo, lat);

    // MTLO in IDLE.
    bus.wr_lo   = 1'b1;
    bus.wr_data = 32'h0000_ABCD;
    tick();
    bus.wr_lo = 1'b0;
    check("mtlo_lo", 64'(bus.lo), 64'hABCD);
    check("mtlo_hi", 64'(bus.hi), 64'h12);
    $display("[TB] mtlo 0x0000abcd -> lo=0x%08h", bus.lo);

    // start with wr_hi in the same cycle: write dropped.
    bus.wr_hi   = 1'b1;
    bus.wr_data = 32'h0000_DEAD;
    issue(OP_MULTU, 32'd2, 32'd3);
    bus.wr_hi = 1'b0;
    check("start_wrhi_hi", 64'(bus.hi), 64'h12);
    wait_done(0, lat, bc);
    check("start_wrhi_res_hi", 64'(bus.hi), 64'd0);
    check("start_wrhi_res_lo", 64'(bus.lo), 64'd6);
    $display("[TB] start+wr_hi multu 2*3 -> hi=0x%08h lo=0x%08h", bus.hi, bus.lo);

    // Reset at iteration 10 of a DIV.
    issue(OP_DIV, 32'd100, 32'd7);
    repeat (9) tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("midrst_busy", 64'(bus.busy), 64'd0);
    check("midrst_hi",   64'(bus.hi),   64'd0);
    check("midrst_lo",   64'(bus.lo),   64'd0);
    check("midrst_done", 64'(bus.done), 64'd0);
    n_done = 0;
    repeat (40) begin
      tick();
      if (bus.done) n_done++;
    end
    check("midrst_no_done", 64'(n_done), 64'd0);
    $display("[TB] reset at iteration 10 -> busy=%0b hi=0x%08h lo=0x%08h", bus.busy, bus.hi, bus.lo);

    run_op("divu_after_rst", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
